unidade_controle_busca: RTL and testbench
=========================================

# unidade_controle_busca

Control unit that sequences the Experiment 3 datapath: a 74163-style 4-bit counter plus a 7485-style comparator, where the comparator's B input is the `chaves` switches. On `iniciar` it clears the counter, then steps it upward at a programmable rate, checking `igual` after every step. It finishes in an "found" state when `igual` is seen, or in a "not found" state when the counter reaches 15 (`fim`) without a match. It sits beside the datapath at the top level and drives the datapath's `zera`/`carrega`/`conta` inputs.

## Interface
- `PERIODO`, default 4: clock cycles per count step; legal range 1..256.
- `clock  in  1`: system clock; all state changes on the rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `iniciar  in  1`: level; starts a search when sampled high in `inicial`, `achou` or `falhou`.
- `igual  in  1`: datapath comparator equality output (counter == chaves).
- `fim  in  1`: datapath counter rco (counter == 15).
- `zera  out  1`: datapath synchronous clear request.
- `carrega  out  1`: datapath load request; constant 0 in this revision.
- `conta  out  1`: datapath count enable, one-cycle pulse per step.
- `pronto  out  1`: high in `achou` and `falhou`.
- `encontrado  out  1`: high only in `achou`.
- `db_estado  out  4`: current state code, for debug.

## Operation
- Moore FSM. Outputs are decoded from the state register only.
- State codes:
  - `inicial`=0: all outputs 0.
  - `preparacao`=1: `zera`=1.
  - `compara`=2.
  - `espera`=3.
  - `conta_passo`=4: `conta`=1.
  - `achou`=5: `pronto`=1, `encontrado`=1.
  - `falhou`=6: `pronto`=1.
- Unused codes go to `inicial`.
- Transitions:
  - `inicial`: `iniciar`=1 goes to `preparacao`; otherwise stays.
  - `preparacao` always goes to `compara`. The counter clears on the same edge.
  - `compara`: `igual`=1 goes to `achou`. Else `fim`=1 goes to `falhou`. Else, if PERIODO>1, go to `espera`; if PERIODO=1, go to `conta_passo`.
  - `igual` has priority over `fim`, so `chaves`=15 ends in `achou`.
  - `espera` holds for exactly PERIODO-1 cycles, then goes to `conta_passo`.
  - `conta_passo` always goes to `compara`. The counter increments on that edge.
  - `achou` and `falhou`: `iniciar`=1 goes to `preparacao`; otherwise hold. A held-high `iniciar` therefore restarts immediately.
- Wait timer:
  - Width is clog2(PERIODO), minimum 1 bit.
  - It is cleared whenever the FSM is not in `espera`.
  - It increments in `espera`.
  - The exit condition is timer == PERIODO-2.
- `igual` and `fim` are sampled only in `compara`; their values in other states are ignored.
- The controller never relies on the counter's power-up value, because `preparacao` always clears it.

## Timing
- Reset values: state=`inicial`, timer=0, and every output 0 (`db_estado`=0).
- `reset_n` low at any point, including mid-search, forces `inicial` immediately and asynchronously. Outputs drop to 0 without waiting for a clock edge.
- The datapath counter is not reset by `reset_n`. It keeps its value until the next `preparacao`.
- Let edge k be the edge that samples `iniciar`=1:
  - `zera` is high during cycle k..k+1.
  - The counter reads 0 after edge k+1.
  - The first `compara` occupies cycle k+1..k+2.
- Each step lasts PERIODO+1 cycles: PERIODO-1 in `espera`, 1 in `conta_passo`, 1 in `compara`.
- For `chaves`=v, `achou` is entered at edge k+2+v·(PERIODO+1).
- For a search with no match, `falhou` is entered at edge k+2+15·(PERIODO+1).
- Exactly v pulses of `conta` are issued before `achou`, and 15 before `falhou`.

## Structure
- Shared package `exp3_pkg` holds:
  - the 4-bit state code constants listed above;
  - the width constant for `db_estado`.
- One sub-module, `temporizador_espera`:
  - parameter PERIODO;
  - inputs `clock`, `reset_n`, `conta_en`, `limpa`;
  - output `terminou`;
  - behaves as the wait timer described above.
- No datapath logic inside this block. The top level instantiates the controller, `contador_163` and `comparador_85` side by side.

## Test plan
- Reset check: `reset_n`=0 at time 0, release, idle 10 cycles with `iniciar`=0 -> `db_estado`=0 and all outputs 0 throughout.
- Immediate match: PERIODO=4, `chaves`=0, behavioural datapath model attached, 1-cycle `iniciar` pulse at edge k -> `zera` high for one cycle, `achou` at edge k+2, `pronto`=`encontrado`=1, zero `conta` pulses.
- Mid-range match: PERIODO=4, `chaves`=9 -> `achou` at edge k+47, exactly 9 `conta` pulses spaced 5 cycles apart, final counter=9.
- Priority and no-match:
  - PERIODO=1, `chaves`=15 -> `achou` (not `falhou`) at edge k+32.
  - Force `igual`=0 -> `falhou` at edge k+32, `encontrado`=0.
- Reset mid-search: assert `reset_n`=0 during `espera` of step 3 -> outputs 0 asynchronously. After release, `iniciar` restarts and the counter is cleared again.
- Held `iniciar`: `iniciar`=1 continuously with `chaves`=2 -> `achou`, then `preparacao` on the next edge, with the search repeating indefinitely.

Source files
------------

// File: rtl/exp3_pkg.sv
// Shared definitions for the Experiment 3 search controller: state codes
// and the width of the debug state output.
package exp3_pkg;

   localparam int DB_ESTADO_W = 4;

   typedef enum logic [DB_ESTADO_W-1:0] {
      INICIAL     = 4'd0,
      PREPARACAO  = 4'd1,
      COMPARA     = 4'd2,
      ESPERA      = 4'd3,
      CONTA_PASSO = 4'd4,
      ACHOU       = 4'd5,
      FALHOU      = 4'd6
   } estado_t;

endpackage

// File: rtl/temporizador_espera.sv
// Wait timer for the espera state: counts cycles while enabled and flags the
// last waiting cycle so the controller spends exactly PERIODO-1 cycles there.
module temporizador_espera #(
   parameter int PERIODO = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic conta_en,
   input  logic limpa,
   output logic terminou
);

   localparam int W = (PERIODO > 1) ? $clog2(PERIODO) : 1;
   // With PERIODO=1 espera is never entered, so the target value is irrelevant.
   localparam logic [W-1:0] ALVO = (PERIODO >= 2) ? W'(PERIODO - 2) : '0;

   logic [W-1:0] timer;

   // Timer register: clear outside espera, advance once per cycle inside it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timer <= '0;
      end else if (limpa) begin
         timer <= '0;
      end else if (conta_en) begin
         timer <= timer + W'(1);
      end
   end

   assign terminou = (PERIODO >= 2) && (timer == ALVO);

endmodule

// File: rtl/unidade_controle_busca.sv
// Search controller for the counter/comparator datapath: clears the counter,
// steps it at a programmable rate and stops on a match or at count 15.
module unidade_controle_busca
   import exp3_pkg::*;
#(
   parameter int PERIODO = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   iniciar,
   input  logic                   igual,
   input  logic                   fim,
   output logic                   zera,
   output logic                   carrega,
   output logic                   conta,
   output logic                   pronto,
   output logic                   encontrado,
   output logic [DB_ESTADO_W-1:0] db_estado
);

   estado_t estado;
   estado_t proximo;
   logic    em_espera;
   logic    terminou;

   assign em_espera = (estado == ESPERA);

   temporizador_espera #(
      .PERIODO (PERIODO)
   ) u_temporizador (
      .clock    (clock),
      .reset_n  (reset_n),
      .conta_en (em_espera),
      .limpa    (!em_espera),
      .terminou (terminou)
   );

   // State register with asynchronous return to inicial.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado <= INICIAL;
      end else begin
         estado <= proximo;
      end
   end

   // Next-state logic; igual wins over fim so a match on 15 is still found.
   always_comb begin
      proximo = INICIAL;
      case (estado)
         INICIAL:     proximo = iniciar ? PREPARACAO : INICIAL;
         PREPARACAO:  proximo = COMPARA;
         COMPARA: begin
            if (igual)             proximo = ACHOU;
            else if (fim)          proximo = FALHOU;
            else if (PERIODO > 1)  proximo = ESPERA;
            else                   proximo = CONTA_PASSO;
         end
         ESPERA:      proximo = terminou ? CONTA_PASSO : ESPERA;
         CONTA_PASSO: proximo = COMPARA;
         ACHOU:       proximo = iniciar ? PREPARACAO : ACHOU;
         FALHOU:      proximo = iniciar ? PREPARACAO : FALHOU;
         default:     proximo = INICIAL;
      endcase
   end

   // Moore output decode from the state register only.
   always_comb begin
      zera       = 1'b0;
      carrega    = 1'b0;
      conta      = 1'b0;
      pronto     = 1'b0;
      encontrado = 1'b0;
      case (estado)
         PREPARACAO:  zera = 1'b1;
         CONTA_PASSO: conta = 1'b1;
         ACHOU: begin
            pronto     = 1'b1;
            encontrado = 1'b1;
         end
         FALHOU:      pronto = 1'b1;
         default:     ;
      endcase
      db_estado = estado;
   end

endmodule

// File: tb/tb_unidade_controle_busca.sv
// Bench for unidade_controle_busca: two controller instances (PERIODO=4 and
// PERIODO=1), each with a behavioural counter/comparator datapath model.
module tb_unidade_controle_busca;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // instance 0: PERIODO=4
   logic       ini4 = 1'b0, frc4 = 1'b0;
   logic [3:0] ch4 = 4'd0, cnt4 = 4'd7;
   logic       igual4, fim4, zera4, carrega4, conta4, pronto4, enc4;
   logic [3:0] db4;
   // instance 1: PERIODO=1
   logic       ini1 = 1'b0, frc1 = 1'b0;
   logic [3:0] ch1 = 4'd0, cnt1 = 4'd7;
   logic       igual1, fim1, zera1, carrega1, conta1, pronto1, enc1;
   logic [3:0] db1;

   unidade_controle_busca #(.PERIODO(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .iniciar(ini4), .igual(igual4), .fim(fim4),
      .zera(zera4), .carrega(carrega4), .conta(conta4), .pronto(pronto4),
      .encontrado(enc4), .db_estado(db4));

   unidade_controle_busca #(.PERIODO(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .iniciar(ini1), .igual(igual1), .fim(fim1),
      .zera(zera1), .carrega(carrega1), .conta(conta1), .pronto(pronto1),
      .encontrado(enc1), .db_estado(db1));

   // behavioural datapath models (counter not affected by reset_n)
   always @(posedge clock) begin
      if (zera4) cnt4 <= 4'd0; else if (conta4) cnt4 <= cnt4 + 4'd1;
      if (zera1) cnt1 <= 4'd0; else if (conta1) cnt1 <= cnt1 + 4'd1;
   end
   assign igual4 = (cnt4 == ch4) && !frc4;
   assign fim4   = (cnt4 == 4'd15);
   assign igual1 = (cnt1 == ch1) && !frc1;
   assign fim1   = (cnt1 == 4'd15);

   // selected-instance view
   int         sel = 0;
   logic [3:0] db_s, cnt_s;
   logic       zera_s, carrega_s, conta_s, pronto_s, enc_s;
   always_comb begin
      if (sel == 0) begin
         db_s = db4; cnt_s = cnt4; zera_s = zera4; carrega_s = carrega4;
         conta_s = conta4; pronto_s = pronto4; enc_s = enc4;
      end else begin
         db_s = db1; cnt_s = cnt1; zera_s = zera1; carrega_s = carrega1;
         conta_s = conta1; pronto_s = pronto1; enc_s = enc1;
      end
   end

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic set_ini(input int s, input logic v);
      if (s == 0) ini4 = v; else ini1 = v;
   endtask

   // Start a search on instance s and follow it until pronto.
   task automatic run_search(input int s, input logic [3:0] ch, input logic frc,
                             input logic hold, input int exp_st, input int exp_n,
                             input int exp_p, input string name);
      int n, pulses, last, spacing_err, per;
      per = (s == 0) ? 5 : 2;
      sel = s;
      if (s == 0) begin ch4 = ch; frc4 = frc; end else begin ch1 = ch; frc1 = frc; end
      @(negedge clock);
      set_ini(s, 1'b1);
      @(posedge clock);
      #1;
      check({name, " prep state"}, int'(db_s), 1);
      check({name, " zera"}, int'(zera_s), 1);
      if (!hold) set_ini(s, 1'b0);
      n = 0; pulses = 0; last = 0; spacing_err = 0;
      while (n < 2000) begin
         @(posedge clock);
         n++;
         #1;
         if (n == 1) begin
            check({name, " first compara"}, int'(db_s), 2);
            check({name, " counter cleared"}, int'(cnt_s), 0);
         end
         if (conta_s) begin
            pulses++;
            if (pulses > 1 && (n - last) != per) spacing_err++;
            last = n;
         end
         if (pronto_s) break;
      end
      check({name, " end edge"}, n, exp_n);
      check({name, " end state"}, int'(db_s), exp_st);
      check({name, " conta pulses"}, pulses, exp_p);
      check({name, " pulse spacing errors"}, spacing_err, 0);
      check({name, " encontrado"}, int'(enc_s), (exp_st == 5) ? 1 : 0);
      check({name, " final counter"}, int'(cnt_s), (exp_st == 5) ? int'(ch) : 15);
      check({name, " carrega"}, int'(carrega_s), 0);
   endtask

   typedef struct {
      int         s;
      logic [3:0] ch;
      logic       frc;
      int         exp_st;
      int         exp_n;
      int         exp_p;
      string      name;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int n;
      vecs[0] = '{0, 4'd0,  1'b0, 5,  2,  0, "p4_ch0"};
      vecs[1] = '{0, 4'd9,  1'b0, 5, 47,  9, "p4_ch9"};
      vecs[2] = '{0, 4'd3,  1'b0, 5, 17,  3, "p4_ch3"};
      vecs[3] = '{0, 4'd15, 1'b0, 5, 77, 15, "p4_ch15"};
      vecs[4] = '{0, 4'd6,  1'b1, 6, 77, 15, "p4_nomatch"};
      vecs[5] = '{1, 4'd15, 1'b0, 5, 32, 15, "p1_ch15"};
      vecs[6] = '{1, 4'd15, 1'b1, 6, 32, 15, "p1_nomatch"};

      // reset and idle
      #1;
      check("reset db_estado async", int'(db4), 0);
      #22;
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         check("idle outputs p4", int'({db4, zera4, carrega4, conta4, pronto4, enc4}), 0);
         check("idle outputs p1", int'({db1, zera1, carrega1, conta1, pronto1, enc1}), 0);
      end

      // table-driven searches
      foreach (vecs[i])
         run_search(vecs[i].s, vecs[i].ch, vecs[i].frc, 1'b0, vecs[i].exp_st,
                    vecs[i].exp_n, vecs[i].exp_p, vecs[i].name);

      // reset during espera of step 3 (counter==2)
      sel = 0; ch4 = 4'd9; frc4 = 1'b0;
      @(negedge clock);
      ini4 = 1'b1;
      @(posedge clock);
      #1;
      ini4 = 1'b0;
      n = 0;
      while (!(cnt4 == 4'd2 && db4 == 4'd3) && n < 500) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("reach step3 espera", int'(n < 500), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset db_estado", int'(db4), 0);
      check("async reset outputs", int'({zera4, carrega4, conta4, pronto4, enc4}), 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("after reset idle", int'(db4), 0);
      check("counter kept over reset", int'(cnt4), 2);
      run_search(0, 4'd4, 1'b0, 1'b0, 5, 22, 4, "restart_ch4");

      // held iniciar: immediate restart, repeating search
      run_search(0, 4'd2, 1'b0, 1'b1, 5, 12, 2, "held_first");
      @(posedge clock);
      #1;
      check("held restart prep", int'(db4), 1);
      n = 0;
      while (n < 500) begin
         @(posedge clock);
         n++;
         #1;
         if (pronto4) break;
      end
      check("held second achou edge", n, 12);
      check("held second state", int'(db4), 5);
      @(posedge clock);
      #1;
      check("held third restart prep", int'(db4), 1);
      ini4 = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
